// File: rtl/lsu_pkg.sv
// Shared encodings for the memory-stage load/store unit: access sizes,
// error codes, FSM states and the alignment rule.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_WORD = 2'b00,
      SZ_HALF = 2'b01,
      SZ_BYTE = 2'b10,
      SZ_RSVD = 2'b11
   } lsu_size_e;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_TIMEOUT  = 2'b10,
      ERR_SIZE     = 2'b11
   } lsu_err_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10
   } lsu_state_e;

   function automatic lsu_err_e access_check(input lsu_size_e size, input logic [1:0] addr_lo);
      lsu_err_e err;
      err = ERR_NONE;
      case (size)
         SZ_RSVD: err = ERR_SIZE;
         SZ_HALF: if (addr_lo[0]) err = ERR_MISALIGN;
         SZ_WORD: if (addr_lo != 2'b00) err = ERR_MISALIGN;
         default: err = ERR_NONE;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/lsu_lane.sv
// Little-endian lane steering: store byte enables and replicated write data,
// plus load lane selection with sign or zero extension.
module lsu_lane
   import lsu_pkg::*;
(
   input  lsu_size_e   size,
   input  logic [1:0]  addr_lo,
   input  logic        we,
   input  logic        sign,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [3:0]  store_be;
   logic [31:0] shifted;
   logic [7:0]  load_byte;
   logic [15:0] load_half;

   always_comb begin
      store_be  = 4'b1111;
      wdata     = store_data;
      load_data = rdata;
      shifted   = rdata >> {addr_lo, 3'b000};
      load_byte = shifted[7:0];
      load_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         SZ_BYTE: begin
            store_be  = 4'b0001 << addr_lo;
            wdata     = {4{store_data[7:0]}};
            load_data = {{24{sign & load_byte[7]}}, load_byte};
         end
         SZ_HALF: begin
            store_be  = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata     = {2{store_data[15:0]}};
            load_data = {{16{sign & load_half[15]}}, load_half};
         end
         default: begin
            store_be  = 4'b1111;
            wdata     = store_data;
            load_data = rdata;
         end
      endcase
      // Reads always fetch the whole word; the lane is picked on return.
      be = we ? store_be : 4'b1111;
   end

endmodule

// File: rtl/pipe_mem_lsu.sv
// Memory stage of the pipeline: accepts one EX instruction at a time, runs a
// single data-memory handshake with timeout, and registers the result for WB.
module pipe_mem_lsu
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] exe_alu_out,
   input  logic [31:0] exe_rt_data_out,
   input  logic        exe_dmem_ena,
   input  logic        exe_dmem_wena,
   input  logic [1:0]  exe_dmem_w_cs,
   input  logic [1:0]  exe_dmem_r_cs,
   input  logic        exe_cutter_sign,
   input  logic        exe_rf_wena,
   input  logic [4:0]  exe_rf_waddr,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_wdata,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic        mem_valid,
   output logic [31:0] mem_result,
   output logic        mem_rf_wena,
   output logic [4:0]  mem_rf_waddr,
   output logic [1:0]  mem_err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   lsu_state_e  state, next_state;
   logic [CW-1:0] cnt;
   logic [31:0] cap_addr, cap_data;
   logic        cap_we, cap_sign, cap_rf_wena;
   lsu_size_e   cap_size;
   logic [4:0]  cap_rf_waddr;

   lsu_size_e   in_size;
   lsu_err_e    in_err;
   logic        accept, start_access, expired, finish;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata, lane_load;

   assign in_ready     = (state == ST_IDLE);
   assign accept       = in_valid & in_ready;
   assign in_size      = exe_dmem_wena ? lsu_size_e'(exe_dmem_w_cs) : lsu_size_e'(exe_dmem_r_cs);
   assign in_err       = exe_dmem_ena ? access_check(in_size, exe_alu_out[1:0]) : ERR_NONE;
   assign start_access = accept & exe_dmem_ena & (in_err == ERR_NONE);
   assign expired      = (cnt == CW'(TIMEOUT - 1));
   assign finish       = (state == ST_ACCESS) & (dm_ack | expired);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:   if (start_access) next_state = ST_ACCESS;
         ST_ACCESS: if (dm_ack || expired) next_state = ST_RESP;
         ST_RESP:   next_state = ST_IDLE;
         default:   next_state = ST_IDLE;
      endcase
   end

   // The counter sits at zero outside ACCESS, so it is clear on entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                    cnt <= '0;
      else if (state != ST_ACCESS) cnt <= '0;
      else                         cnt <= cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_addr     <= '0;
         cap_data     <= '0;
         cap_we       <= 1'b0;
         cap_sign     <= 1'b0;
         cap_size     <= SZ_WORD;
         cap_rf_wena  <= 1'b0;
         cap_rf_waddr <= '0;
      end else if (accept) begin
         cap_addr     <= exe_alu_out;
         cap_data     <= exe_rt_data_out;
         cap_we       <= exe_dmem_wena;
         cap_sign     <= exe_cutter_sign;
         cap_size     <= in_size;
         cap_rf_wena  <= exe_rf_wena;
         cap_rf_waddr <= exe_rf_waddr;
      end
   end

   lsu_lane u_lane (
      .size       (cap_size),
      .addr_lo    (cap_addr[1:0]),
      .we         (cap_we),
      .sign       (cap_sign),
      .store_data (cap_data),
      .rdata      (dm_rdata),
      .be         (lane_be),
      .wdata      (lane_wdata),
      .load_data  (lane_load)
   );

   assign dm_req   = (state == ST_ACCESS);
   assign dm_we    = dm_req & cap_we;
   assign dm_addr  = dm_req ? {cap_addr[31:2], 2'b00} : '0;
   assign dm_be    = dm_req ? lane_be : '0;
   assign dm_wdata = dm_req ? lane_wdata : '0;

   // Write-enable and error only mean something alongside mem_valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_valid    <= 1'b0;
         mem_result   <= '0;
         mem_rf_wena  <= 1'b0;
         mem_rf_waddr <= '0;
         mem_err      <= ERR_NONE;
      end else begin
         mem_valid   <= 1'b0;
         mem_rf_wena <= 1'b0;
         mem_err     <= ERR_NONE;
         if (accept && !start_access) begin
            mem_valid    <= 1'b1;
            mem_result   <= exe_alu_out;
            mem_rf_wena  <= exe_rf_wena & (in_err == ERR_NONE);
            mem_rf_waddr <= exe_rf_waddr;
            mem_err      <= in_err;
         end else if (finish) begin
            mem_valid    <= 1'b1;
            mem_rf_waddr <= cap_rf_waddr;
            if (dm_ack) begin
               mem_result  <= cap_we ? cap_addr : lane_load;
               mem_rf_wena <= cap_rf_wena & ~cap_we;
            end else begin
               mem_result <= cap_addr;
               mem_err    <= ERR_TIMEOUT;
            end
         end
      end
   end

endmodule

// File: tb/tb_pipe_mem_lsu.sv
// Randomised transaction bench for pipe_mem_lsu with a per-cycle compare
// against a spec-level model, plus hand-computed directed cases.
module tb_pipe_mem_lsu;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] exe_alu_out, exe_rt_data_out;
   logic        exe_dmem_ena, exe_dmem_wena;
   logic [1:0]  exe_dmem_w_cs, exe_dmem_r_cs;
   logic        exe_cutter_sign, exe_rf_wena;
   logic [4:0]  exe_rf_waddr;
   logic        dm_req, dm_we;
   logic [31:0] dm_addr, dm_wdata;
   logic [3:0]  dm_be;
   logic        dm_ack;
   logic [31:0] dm_rdata;
   logic        mem_valid, mem_rf_wena;
   logic [31:0] mem_result;
   logic [4:0]  mem_rf_waddr;
   logic [1:0]  mem_err;

   int n_checks = 0;
   int n_fail   = 0;

   bit          chk_en = 1'b0;
   logic        exp_in_ready = 1'b1, exp_req = 1'b0, exp_we = 1'b0, exp_mv = 1'b0;
   logic        exp_rfw = 1'b0, exp_chk_res = 1'b0;
   logic [31:0] exp_addr = '0, exp_wdata = '0, exp_result = '0;
   logic [3:0]  exp_be = '0;
   logic [4:0]  exp_waddr = '0;
   logic [1:0]  exp_err = '0;

   int          req_cycles = 0;
   logic [31:0] last_dm_addr = '0, last_dm_wdata = '0, last_result = '0;
   logic [3:0]  last_dm_be = '0;
   logic        last_dm_we = 1'b0, last_rfw = 1'b0;
   logic [1:0]  last_err = '0;

   always #5 clk = ~clk;

   pipe_mem_lsu #(.TIMEOUT(TMO)) dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .exe_alu_out     (exe_alu_out),
      .exe_rt_data_out (exe_rt_data_out),
      .exe_dmem_ena    (exe_dmem_ena),
      .exe_dmem_wena   (exe_dmem_wena),
      .exe_dmem_w_cs   (exe_dmem_w_cs),
      .exe_dmem_r_cs   (exe_dmem_r_cs),
      .exe_cutter_sign (exe_cutter_sign),
      .exe_rf_wena     (exe_rf_wena),
      .exe_rf_waddr    (exe_rf_waddr),
      .dm_req          (dm_req),
      .dm_we           (dm_we),
      .dm_addr         (dm_addr),
      .dm_be           (dm_be),
      .dm_wdata        (dm_wdata),
      .dm_ack          (dm_ack),
      .dm_rdata        (dm_rdata),
      .mem_valid       (mem_valid),
      .mem_result      (mem_result),
      .mem_rf_wena     (mem_rf_wena),
      .mem_rf_waddr    (mem_rf_waddr),
      .mem_err         (mem_err)
   );

   function automatic logic [1:0] ref_err(input logic mem, input logic [1:0] size, input logic [31:0] addr);
      if (!mem) return 2'd0;
      if (size == 2'd3) return 2'd3;
      if (size == 2'd1 && addr[0]) return 2'd1;
      if (size == 2'd0 && addr[1:0] != 2'd0) return 2'd1;
      return 2'd0;
   endfunction

   function automatic logic [3:0] ref_be(input logic we, input logic [1:0] size, input logic [1:0] lo);
      if (!we || size == 2'd0) return 4'hF;
      if (size == 2'd1) return lo[1] ? 4'hC : 4'h3;
      return 4'(1 << lo);
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] data);
      if (size == 2'd2) return data[7:0] * 32'h0101_0101;
      if (size == 2'd1) return data[15:0] * 32'h0001_0001;
      return data;
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sign,
                                            input logic [31:0] addr, input logic [31:0] rdata);
      logic [31:0] v;
      if (size == 2'd2) begin
         v = (rdata >> (8 * int'(addr[1:0]))) & 32'hFF;
         if (sign && v >= 32'h80) v = v | 32'hFFFF_FF00;
         return v;
      end
      if (size == 2'd1) begin
         v = (rdata >> (16 * int'(addr[1]))) & 32'hFFFF;
         if (sign && v >= 32'h8000) v = v | 32'hFFFF_0000;
         return v;
      end
      return rdata;
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
      end
   endtask

   task automatic scramble();
      exe_alu_out     = $urandom;
      exe_rt_data_out = $urandom;
      exe_dmem_ena    = 1'($urandom);
      exe_dmem_wena   = 1'($urandom);
      exe_dmem_w_cs   = 2'($urandom);
      exe_dmem_r_cs   = 2'($urandom);
      exe_cutter_sign = 1'($urandom);
      exe_rf_wena     = 1'($urandom);
      exe_rf_waddr    = 5'($urandom);
   endtask

   // One instruction from issue to return-to-idle; sets the expected outputs
   // for each upcoming sampling edge from the spec-level timeline.
   task automatic apply_stimulus(input logic mem, input logic we, input logic [1:0] size,
                                 input logic sign, input logic [31:0] addr, input logic [31:0] data,
                                 input logic rfw, input logic [4:0] waddr,
                                 input int ack_delay, input logic [31:0] rdata);
      logic [1:0] err;
      int n_req;
      err = ref_err(mem, size, addr);
      @(negedge clk);
      in_valid        = 1'b1;
      exe_alu_out     = addr;
      exe_rt_data_out = data;
      exe_dmem_ena    = mem;
      exe_dmem_wena   = we;
      exe_dmem_w_cs   = we ? size : 2'($urandom);
      exe_dmem_r_cs   = we ? 2'($urandom) : size;
      exe_cutter_sign = sign;
      exe_rf_wena     = rfw;
      exe_rf_waddr    = waddr;
      dm_ack          = 1'($urandom);
      dm_rdata        = $urandom;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      scramble();
      exp_waddr = waddr;
      if (!mem || err != 2'd0) begin
         exp_mv      = 1'b1;
         exp_result  = addr;
         exp_chk_res = 1'b1;
         exp_rfw     = mem ? 1'b0 : rfw;
         exp_err     = err;
         @(posedge clk); #1;
         exp_mv = 1'b0;
      end else begin
         n_req        = (ack_delay < TMO) ? ack_delay + 1 : TMO;
         exp_in_ready = 1'b0;
         exp_req      = 1'b1;
         exp_addr     = {addr[31:2], 2'b00};
         exp_we       = we;
         exp_be       = ref_be(we, size, addr[1:0]);
         exp_wdata    = ref_wdata(size, data);
         for (int k = 0; k < n_req; k++) begin
            dm_ack   = (k == ack_delay);
            dm_rdata = (k == ack_delay) ? rdata : $urandom;
            @(posedge clk); #1;
         end
         dm_ack   = 1'($urandom);
         dm_rdata = $urandom;
         exp_req  = 1'b0;
         exp_mv   = 1'b1;
         if (ack_delay < TMO) begin
            exp_err     = 2'd0;
            exp_chk_res = 1'b1;
            exp_result  = we ? addr : ref_load(size, sign, addr, rdata);
            exp_rfw     = we ? 1'b0 : rfw;
         end else begin
            exp_err     = 2'd2;
            exp_chk_res = 1'b0;
            exp_rfw     = 1'b0;
         end
         @(posedge clk); #1;
         exp_mv       = 1'b0;
         exp_in_ready = 1'b1;
      end
      dm_ack = 1'b0;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check_output("in_ready", in_ready, exp_in_ready);
         check_output("dm_req", dm_req, exp_req);
         if (exp_req) begin
            check_output("dm_addr", dm_addr, exp_addr);
            check_output("dm_we", dm_we, exp_we);
            check_output("dm_be", dm_be, exp_be);
            if (exp_we) check_output("dm_wdata", dm_wdata, exp_wdata);
         end
         check_output("mem_valid", mem_valid, exp_mv);
         if (exp_mv) begin
            if (exp_chk_res) check_output("mem_result", mem_result, exp_result);
            check_output("mem_rf_wena", mem_rf_wena, exp_rfw);
            check_output("mem_rf_waddr", mem_rf_waddr, exp_waddr);
            check_output("mem_err", mem_err, exp_err);
         end
      end
   end

   always @(negedge clk) begin
      if (dm_req) begin
         req_cycles++;
         last_dm_addr  = dm_addr;
         last_dm_be    = dm_be;
         last_dm_wdata = dm_wdata;
         last_dm_we    = dm_we;
      end
      if (mem_valid) begin
         last_result = mem_result;
         last_err    = mem_err;
         last_rfw    = mem_rf_wena;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int base;
      logic        r_mem, r_we, r_sign, r_rfw;
      logic [1:0]  r_size;
      logic [31:0] r_addr;

      in_valid = 1'b0;
      scramble();
      dm_ack   = 1'b0;
      dm_rdata = '0;
      rst      = 1'b1;
      #1 rst   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_output("reset_in_ready", in_ready, 1'b1);
      check_output("reset_dm_req", dm_req, 1'b0);
      check_output("reset_dm_we", dm_we, 1'b0);
      check_output("reset_dm_addr", dm_addr, 32'h0);
      check_output("reset_dm_be", dm_be, 4'h0);
      check_output("reset_dm_wdata", dm_wdata, 32'h0);
      check_output("reset_mem_valid", mem_valid, 1'b0);
      check_output("reset_mem_result", mem_result, 32'h0);
      check_output("reset_mem_rf_wena", mem_rf_wena, 1'b0);
      check_output("reset_mem_rf_waddr", mem_rf_waddr, 5'h0);
      check_output("reset_mem_err", mem_err, 2'b00);
      rst    = 1'b1;
      chk_en = 1'b1;

      base = req_cycles;
      apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_1234, 32'h0, 1'b1, 5'd3, 0, 32'h0);
      check_output("alu_result", last_result, 32'h0000_1234);
      check_output("alu_no_req", req_cycles - base, 0);

      base = req_cycles;
      apply_stimulus(1'b1, 1'b0, 2'd2, 1'b1, 32'h0000_0103, 32'h0, 1'b1, 5'd7, 2, 32'h80FF_FF00);
      check_output("lb_dm_addr", last_dm_addr, 32'h0000_0100);
      check_output("lb_result", last_result, 32'hFFFF_FF80);
      check_output("lb_req_cycles", req_cycles - base, 3);

      apply_stimulus(1'b1, 1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'hABCD_1234, 1'b1, 5'd9, 0, 32'h0);
      check_output("sh_dm_be", last_dm_be, 4'b1100);
      check_output("sh_dm_wdata", last_dm_wdata, 32'h1234_1234);
      check_output("sh_dm_we", last_dm_we, 1'b1);
      check_output("sh_rf_wena", last_rfw, 1'b0);

      base = req_cycles;
      apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0101, 32'h0, 1'b1, 5'd4, 0, 32'h0);
      check_output("lw_mis_no_req", req_cycles - base, 0);
      check_output("lw_mis_err", last_err, 2'b01);
      check_output("lw_mis_rf_wena", last_rfw, 1'b0);

      base = req_cycles;
      apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0200, 32'h0, 1'b1, 5'd5, 99, 32'h0);
      check_output("lw_tmo_req_cycles", req_cycles - base, TMO);
      check_output("lw_tmo_err", last_err, 2'b10);

      // Reset asserted mid-access; later acks must not resurrect it.
      chk_en = 1'b0;
      @(negedge clk);
      in_valid      = 1'b1;
      exe_alu_out   = 32'h0000_0300;
      exe_dmem_ena  = 1'b1;
      exe_dmem_wena = 1'b0;
      exe_dmem_r_cs = 2'd0;
      dm_ack        = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #3;
      check_output("rst_mid_req_before", dm_req, 1'b1);
      rst = 1'b0;
      #1;
      check_output("rst_mid_req_async", dm_req, 1'b0);
      check_output("rst_mid_in_ready", in_ready, 1'b1);
      check_output("rst_mid_dm_addr", dm_addr, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         dm_ack   = 1'b1;
         dm_rdata = $urandom;
         @(posedge clk); #1;
         check_output("rst_late_ack_req", dm_req, 1'b0);
         check_output("rst_late_ack_valid", mem_valid, 1'b0);
         check_output("rst_late_ack_ready", in_ready, 1'b1);
      end
      dm_ack       = 1'b0;
      exp_in_ready = 1'b1;
      exp_req      = 1'b0;
      exp_mv       = 1'b0;
      chk_en       = 1'b1;

      for (int i = 0; i < 250; i++) begin
         r_mem  = ($urandom_range(0, 9) < 7);
         r_we   = 1'($urandom);
         r_size = 2'($urandom);
         r_sign = 1'($urandom);
         r_rfw  = 1'($urandom);
         r_addr = $urandom;
         if ($urandom_range(0, 1) == 0) r_addr[1:0] = 2'b00;
         apply_stimulus(r_mem, r_we, r_size, r_sign, r_addr, $urandom, r_rfw, 5'($urandom),
                        $urandom_range(0, TMO + 1), $urandom);
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_mem_lsu.md
PIPE_MEM_LSU -- requirements
Module: pipe_mem_lsu

Interface
REQ-001 SHALL have clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have in_valid  in  1  EX stage presents an instruction.
REQ-004 SHALL have in_ready  out  1  LSU accepts the EX instruction this cycle; upstream stall = ~in_ready.
REQ-005 SHALL have exe_alu_out  in  32  ALU result, used as byte address when exe_dmem_ena=1.
REQ-006 SHALL have exe_rt_data_out  in  32  store data.
REQ-007 SHALL have exe_dmem_ena, exe_dmem_wena  in  1 each  memory access, write (1) or read (0).
REQ-008 SHALL have exe_dmem_w_cs, exe_dmem_r_cs  in  2 each  access size: 00 word, 01 half, 10 byte, 11 reserved.
REQ-009 SHALL have exe_cutter_sign  in  1  sign-extend loaded half/byte when 1, zero-extend when 0.
REQ-010 SHALL have exe_rf_wena  in  1, and exe_rf_waddr  in  5; both forwarded to WB.
REQ-011 SHALL have dm_req  out  1, dm_we  out  1, dm_addr  out  32 (word-aligned, bits[1:0]=00), dm_be  out  4, dm_wdata  out  32.
REQ-012 SHALL have dm_ack  in  1 and dm_rdata  in  32; dm_rdata valid in the dm_ack cycle.
REQ-013 SHALL have mem_valid  out  1, mem_result  out  32, mem_rf_wena  out  1, mem_rf_waddr  out  5: registered result to WB.
REQ-014 SHALL have mem_err  out  2: 00 none, 01 misaligned, 10 timeout, 11 reserved-size.
REQ-015 SHALL have parameter TIMEOUT, default 255, maximum dm_ack wait cycles.

Function
REQ-016 SHALL implement FSM IDLE, ACCESS, RESP; in_ready=1 only in IDLE.
REQ-017 SHALL capture the instruction on in_valid & in_ready (cycle T).
REQ-018 Non-memory instruction: SHALL stay in IDLE; mem_valid=1 at T+1 with mem_result=exe_alu_out.
REQ-019 Memory access, aligned, size valid: SHALL enter ACCESS at T+1; dm_req held high from T+1 through the dm_ack cycle A inclusive; dm_addr/dm_we/dm_be/dm_wdata stable while dm_req=1.
REQ-020 SHALL enter RESP at A+1 with mem_valid=1 for exactly one cycle, then IDLE at A+2 (in_ready=1 at A+2).
REQ-021 Alignment: half requires addr[0]=0, word requires addr[1:0]=00; violation or size 11 SHALL suppress dm_req, force mem_rf_wena=0, set mem_err, mem_valid=1 at T+1.
REQ-022 Store lanes little-endian: byte -> dm_be=1<<addr[1:0], data byte replicated to all 4 lanes; half -> dm_be=0011 (addr[1]=0) or 1100, half replicated; word -> 1111.
REQ-023 Load: select lane per addr[1:0], extend to 32 bits per exe_cutter_sign; dm_be=1111 on reads.
REQ-024 Stores SHALL force mem_rf_wena=0 and mem_result=exe_alu_out.
REQ-025 Timeout counter SHALL clear on entering ACCESS; if TIMEOUT cycles elapse without dm_ack, SHALL drop dm_req, set mem_err=10, mem_rf_wena=0, go RESP.
REQ-026 dm_ack outside ACCESS SHALL be ignored.
REQ-027 mem_err SHALL be 00 on every successful completion; valid only with mem_valid.

Reset
REQ-028 rst=0 SHALL immediately force state IDLE, dm_req=0, mem_valid=0, mem_rf_wena=0, mem_err=00, all data outputs 0, counter 0, including mid-ACCESS; an outstanding access is abandoned.

Structure
REQ-029 Size codes, error codes and FSM state encoding SHALL live in shared package lsu_pkg.
REQ-030 Lane selection/extension and byte-enable generation SHALL be one combinational sub-module lsu_lane.

Verification
REQ-031 ALU op, in_valid=1, exe_alu_out=0x1234 -> mem_valid at T+1, mem_result=0x1234, no dm_req.
REQ-032 lb addr 0x103, sign=1, dm_rdata=0x80FF_FF00, ack after 3 cycles -> dm_addr=0x100, mem_result=0xFFFF_FF80, mem_valid at A+1.
REQ-033 sh addr 0x102, data 0xABCD_1234 -> dm_be=1100, dm_wdata=0x1234_1234, dm_we=1, mem_rf_wena=0.
REQ-034 lw addr 0x101 -> no dm_req, mem_err=01, mem_valid at T+1, mem_rf_wena=0.
REQ-035 lw, dm_ack never asserted, TIMEOUT=4 -> dm_req drops after 4 cycles, mem_err=10.
REQ-036 rst=0 during ACCESS -> dm_req=0 asynchronously; after release in_ready=1, later dm_ack ignored.
